// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//   Branch/jump resolution for the single-cycle MIPS-style CPU. Resolves the
//   decoded branch control against the register-file operands and produces
//   registered taken flags, the byte offset of a taken conditional branch and
//   the absolute target of an unconditional jump. Outputs feed PC-select.
//
// Ports
//   clk          in   1   system clock, outputs update on the rising edge
//   reset        in   1   asynchronous active-high reset, clears all outputs
//   ctrl         in   2   0=none, 1=BEQ, 2=J, 3=BNE
//   pc_h4        in   4   PC[31:28] of PC+4, upper bits of the jump target
//   im_offset    in  16   signed branch immediate, in words
//   instr_index  in  26   jump instruction index field
//   inum1        in  32   first comparison operand (rs)
//   inum2        in  32   second comparison operand (rt)
//   _branch      out  1   conditional branch taken
//   _offset      out 32   sign_extend(im_offset) << 2 when taken, else 0
//   _jump        out  1   unconditional jump taken
//   _target      out 32   {pc_h4, instr_index, 2'b00} when jumping, else 0
// -----------------------------------------------------------------------------
module branch_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  ctrl,
   input  logic [3:0]  pc_h4,
   input  logic [15:0] im_offset,
   input  logic [25:0] instr_index,
   input  logic [31:0] inum1,
   input  logic [31:0] inum2,
   output logic        _branch,
   output logic [31:0] _offset,
   output logic        _jump,
   output logic [31:0] _target
);

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_BEQ  = 2'd1,
      OP_J    = 2'd2,
      OP_BNE  = 2'd3
   } op_e;

   op_e         op;
   logic        operands_equal;
   logic [31:0] branch_offset;
   logic [31:0] jump_target;

   logic        branch_nxt;
   logic [31:0] offset_nxt;
   logic        jump_nxt;
   logic [31:0] target_nxt;

   assign op             = op_e'(ctrl);
   assign operands_equal = (inum1 == inum2);
   assign branch_offset  = {{14{im_offset[15]}}, im_offset, 2'b00};
   assign jump_target    = {pc_h4, instr_index, 2'b00};

   // Only the fields that the selected operation uses are routed to the
   // next-state values, so X on the unused inputs never reaches the outputs.
   always_comb begin
      branch_nxt = 1'b0;
      offset_nxt = '0;
      jump_nxt   = 1'b0;
      target_nxt = '0;
      case (op)
         OP_BEQ: begin
            if (operands_equal) begin
               branch_nxt = 1'b1;
               offset_nxt = branch_offset;
            end
         end
         OP_BNE: begin
            if (!operands_equal) begin
               branch_nxt = 1'b1;
               offset_nxt = branch_offset;
            end
         end
         OP_J: begin
            jump_nxt   = 1'b1;
            target_nxt = jump_target;
         end
         default: begin
            branch_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         _branch <= 1'b0;
         _offset <= '0;
         _jump   <= 1'b0;
         _target <= '0;
      end else begin
         _branch <= branch_nxt;
         _offset <= offset_nxt;
         _jump   <= jump_nxt;
         _target <= target_nxt;
      end
   end

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

   logic        clk;
   logic        reset;
   logic [1:0]  ctrl;
   logic [3:0]  pc_h4;
   logic [15:0] im_offset;
   logic [25:0] instr_index;
   logic [31:0] inum1;
   logic [31:0] inum2;
   logic        _branch;
   logic [31:0] _offset;
   logic        _jump;
   logic [31:0] _target;

   int pass_cnt;
   int total_cnt;

   branch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .ctrl        (ctrl),
      .pc_h4       (pc_h4),
      .im_offset   (im_offset),
      .instr_index (instr_index),
      .inum1       (inum1),
      .inum2       (inum2),
      ._branch     (_branch),
      ._offset     (_offset),
      ._jump       (_jump),
      ._target     (_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic drive(input logic [1:0] c, input logic [3:0] ph,
                        input logic [15:0] imm, input logic [25:0] idx,
                        input logic [31:0] a, input logic [31:0] b);
      ctrl = c; pc_h4 = ph; im_offset = imm; instr_index = idx;
      inum1 = a; inum2 = b;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      drive(2'd2, 4'hF, 16'hFFFF, 26'h3FFFFFF, 32'd0, 32'd0);
      step(); step();
      total_cnt++;
      if (_branch !== 1'b0) $display("FAIL reset_branch: got %b want 0", _branch);
      else pass_cnt++;
      total_cnt++;
      if (_offset !== 32'h0) $display("FAIL reset_offset: got %h want 00000000", _offset);
      else pass_cnt++;
      total_cnt++;
      if (_jump !== 1'b0) $display("FAIL reset_jump: got %b want 0", _jump);
      else pass_cnt++;
      total_cnt++;
      if (_target !== 32'h0) $display("FAIL reset_target: got %h want 00000000", _target);
      else pass_cnt++;
      drive(2'd0, 4'h0, 16'h0, 26'h0, 32'd0, 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_beq;
      drive(2'd1, 4'h2, 16'hFFFF, 26'h0, 32'd0, 32'd0);
      step();
      total_cnt++;
      if (_branch !== 1'b1) $display("FAIL beq_taken_branch: got %b want 1", _branch);
      else pass_cnt++;
      total_cnt++;
      if (_offset !== 32'hFFFFFFFC) $display("FAIL beq_taken_offset: got %h want fffffffc", _offset);
      else pass_cnt++;
      total_cnt++;
      if (_jump !== 1'b0) $display("FAIL beq_taken_jump: got %b want 0", _jump);
      else pass_cnt++;
      total_cnt++;
      if (_target !== 32'h0) $display("FAIL beq_taken_target: got %h want 00000000", _target);
      else pass_cnt++;

      drive(2'd1, 4'h2, 16'hFFFF, 26'h0, 32'd1, 32'd0);
      step();
      total_cnt++;
      if (_branch !== 1'b0) $display("FAIL beq_nt_branch: got %b want 0", _branch);
      else pass_cnt++;
      total_cnt++;
      if (_offset !== 32'h0) $display("FAIL beq_nt_offset: got %h want 00000000", _offset);
      else pass_cnt++;

      // only the MSB differs: full-width compare
      drive(2'd1, 4'h0, 16'h0001, 26'h0, 32'h80000000, 32'h0);
      step();
      total_cnt++;
      if (_branch !== 1'b0) $display("FAIL beq_msb_branch: got %b want 0", _branch);
      else pass_cnt++;

      // pc_h4 / instr_index are don't-care for branches
      drive(2'd1, 4'hx, 16'h1234, 26'hx, 32'hDEADBEEF, 32'hDEADBEEF);
      step();
      total_cnt++;
      if (_offset !== 32'h000048D0) $display("FAIL beq_x_offset: got %h want 000048d0", _offset);
      else pass_cnt++;
      total_cnt++;
      if (_target !== 32'h0) $display("FAIL beq_x_target: got %h want 00000000", _target);
      else pass_cnt++;
   endtask

   task automatic test_jump;
      drive(2'd2, 4'h3, 16'h0, 26'd16, 32'd0, 32'd0);
      step();
      total_cnt++;
      if (_jump !== 1'b1) $display("FAIL jump_flag: got %b want 1", _jump);
      else pass_cnt++;
      total_cnt++;
      if (_target !== 32'h30000040) $display("FAIL jump_target: got %h want 30000040", _target);
      else pass_cnt++;
      total_cnt++;
      if (_branch !== 1'b0) $display("FAIL jump_branch: got %b want 0", _branch);
      else pass_cnt++;
      total_cnt++;
      if (_offset !== 32'h0) $display("FAIL jump_offset: got %h want 00000000", _offset);
      else pass_cnt++;

      // operands and immediate are don't-care for J
      drive(2'd2, 4'hA, 16'hxxxx, 26'h3FFFFFF, 32'hx, 32'hx);
      step();
      total_cnt++;
      if (_target !== 32'hAFFFFFFC) $display("FAIL jump_x_target: got %h want affffffc", _target);
      else pass_cnt++;
      total_cnt++;
      if (_offset !== 32'h0 || _branch !== 1'b0)
         $display("FAIL jump_x_branch: got branch=%b offset=%h want 0/00000000", _branch, _offset);
      else pass_cnt++;
   endtask

   task automatic test_bne;
      drive(2'd3, 4'h0, 16'h0004, 26'h0, 32'd5, 32'd7);
      step();
      total_cnt++;
      if (_branch !== 1'b1) $display("FAIL bne_taken_branch: got %b want 1", _branch);
      else pass_cnt++;
      total_cnt++;
      if (_offset !== 32'h00000010) $display("FAIL bne_taken_offset: got %h want 00000010", _offset);
      else pass_cnt++;
      total_cnt++;
      if (_jump !== 1'b0) $display("FAIL bne_taken_jump: got %b want 0", _jump);
      else pass_cnt++;

      inum2 = 32'd5;
      step();
      total_cnt++;
      if (_branch !== 1'b0) $display("FAIL bne_nt_branch: got %b want 0", _branch);
      else pass_cnt++;
      total_cnt++;
      if (_offset !== 32'h0) $display("FAIL bne_nt_offset: got %h want 00000000", _offset);
      else pass_cnt++;
   endtask

   task automatic test_idle_reset;
      drive(2'd0, 4'hF, 16'hFFFF, 26'h3FFFFFF, 32'd1, 32'd2);
      step();
      total_cnt++;
      if (_branch !== 1'b0 || _jump !== 1'b0 || _offset !== 32'h0 || _target !== 32'h0)
         $display("FAIL idle_outputs: got b=%b o=%h j=%b t=%h want all zero",
                  _branch, _offset, _jump, _target);
      else pass_cnt++;

      drive(2'd2, 4'h5, 16'h0, 26'h0000123, 32'd0, 32'd0);
      step();
      total_cnt++;
      if (_jump !== 1'b1 || _target !== 32'h5000048C)
         $display("FAIL preset_jump: got j=%b t=%h want 1/5000048c", _jump, _target);
      else pass_cnt++;

      // between edges: reset must clear without waiting for a clock
      #2;
      reset = 1'b1;
      #1;
      total_cnt++;
      if (_jump !== 1'b0 || _target !== 32'h0 || _branch !== 1'b0 || _offset !== 32'h0)
         $display("FAIL async_reset: got b=%b o=%h j=%b t=%h want all zero",
                  _branch, _offset, _jump, _target);
      else pass_cnt++;

      @(negedge clk);
      reset = 1'b0;
      #1;
      total_cnt++;
      if (_jump !== 1'b0) $display("FAIL post_reset_hold: got %b want 0", _jump);
      else pass_cnt++;
      step();
      total_cnt++;
      if (_jump !== 1'b1 || _target !== 32'h5000048C)
         $display("FAIL post_reset_jump: got j=%b t=%h want 1/5000048c", _jump, _target);
      else pass_cnt++;
   endtask

   task automatic test_offset_extremes;
      drive(2'd1, 4'h0, 16'h8000, 26'h0, 32'd9, 32'd9);
      step();
      total_cnt++;
      if (_offset !== 32'hFFFE0000) $display("FAIL offset_min: got %h want fffe0000", _offset);
      else pass_cnt++;
      im_offset = 16'h7FFF;
      step();
      total_cnt++;
      if (_offset !== 32'h0001FFFC) $display("FAIL offset_max: got %h want 0001fffc", _offset);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      drive(2'd3, 4'h0, 16'hFFFE, 26'h0, 32'hFFFFFFFF, 32'h7FFFFFFF);
      step();
      total_cnt++;
      if (_branch !== 1'b1 || _offset !== 32'hFFFFFFF8)
         $display("FAIL b2b_bne: got b=%b o=%h want 1/fffffff8", _branch, _offset);
      else pass_cnt++;

      // input change mid-cycle must not show before the next edge
      drive(2'd2, 4'h1, 16'h0, 26'h0000001, 32'd0, 32'd0);
      #2;
      total_cnt++;
      if (_jump !== 1'b0 || _branch !== 1'b1)
         $display("FAIL b2b_hold: got b=%b j=%b want 1/0", _branch, _jump);
      else pass_cnt++;
      step();
      total_cnt++;
      if (_jump !== 1'b1 || _target !== 32'h10000004 || _branch !== 1'b0)
         $display("FAIL b2b_jump: got b=%b j=%b t=%h want 0/1/10000004", _branch, _jump, _target);
      else pass_cnt++;

      drive(2'd1, 4'h1, 16'h0010, 26'h0, 32'd3, 32'd3);
      step();
      total_cnt++;
      if (_branch !== 1'b1 || _offset !== 32'h00000040 || _jump !== 1'b0 || _target !== 32'h0)
         $display("FAIL b2b_beq: got b=%b o=%h j=%b t=%h want 1/00000040/0/00000000",
                  _branch, _offset, _jump, _target);
      else pass_cnt++;

      drive(2'd0, 4'h0, 16'h0, 26'h0, 32'd0, 32'd0);
      step();
      total_cnt++;
      if (_branch !== 1'b0 || _offset !== 32'h0)
         $display("FAIL b2b_idle: got b=%b o=%h want 0/00000000", _branch, _offset);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_beq();
      test_jump();
      test_bne();
      test_idle_reset();
      test_offset_extremes();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Branch/jump resolution unit for the single-cycle MIPS-style CPU.
- Takes the decoded branch control, the comparison operands from the register file, the 16-bit branch immediate, the 26-bit jump index and PC[31:28].
- Produces branch-taken and jump-taken flags with the sign-extended word offset and the absolute jump target.
- Outputs are registered and feed the PC-select logic.

Parameters:
- None. All widths are fixed: 32-bit datapath, 16-bit immediate, 26-bit jump index.

Ports:
- clk  input  1  system clock; all outputs update on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all outputs.
- ctrl  input  2  operation: 0=none, 1=BEQ, 2=J, 3=BNE.
- pc_h4  input  4  upper 4 bits of PC+4 (PC[31:28]), used for the jump target.
- im_offset  input  16  signed branch immediate, in words.
- instr_index  input  26  jump instruction index field.
- inum1  input  32  first comparison operand (rs).
- inum2  input  32  second comparison operand (rt).
- _branch  output  1  1 = conditional branch taken.
- _offset  output  32  byte offset = sign_extend(im_offset) << 2; 0 when _branch=0.
- _jump  output  1  1 = unconditional jump taken.
- _target  output  32  {pc_h4, instr_index, 2'b00}; 0 when _jump=0.

Behaviour:
- Reset: asynchronous and active-high. While reset=1, _branch=0, _jump=0, _offset=0 and _target=0 immediately, regardless of clk. The first update after reset deasserts happens on the next rising clk edge.
- Latency: one cycle. All outputs are registered. Inputs sampled at rising edge N appear at the outputs after edge N and hold until edge N+1.
- Combinational next-state, per ctrl:
  - ctrl=0: all four next outputs are 0.
  - ctrl=1 (BEQ): taken = (inum1 == inum2), full 32-bit unsigned equality. When taken: next _branch=1 and next _offset = {{14{im_offset[15]}}, im_offset, 2'b00}. When not taken: next _branch=0 and next _offset=0. Next _jump=0 and next _target=0.
  - ctrl=2 (J): next _jump=1 and next _target = {pc_h4, instr_index, 2'b00}. Next _branch=0 and next _offset=0. inum1/inum2 are ignored.
  - ctrl=3 (BNE): same as BEQ with taken = (inum1 != inum2).
- _branch and _jump are never both 1.
- Offset arithmetic:
  - Sign extension is from bit 15, then a left shift of 2; the result is exactly 32 bits.
  - im_offset=0x8000 gives 0xFFFE0000; im_offset=0x7FFF gives 0x0001FFFC.
- Target arithmetic: pure concatenation, no adder, no carry.
- No handshake. A new operation is accepted every cycle.
- Reset asserted mid-operation: outputs clear immediately. Inputs present at the first rising edge after reset deasserts are evaluated normally.
- X on unused inputs has no effect on outputs:
  - ctrl=0: all inputs are don't-care.
  - ctrl=2: inum1, inum2 and im_offset are don't-care.
  - ctrl=1/3: pc_h4 and instr_index are don't-care.

Test Plan:
- BEQ taken: reset, then ctrl=1, inum1=0, inum2=0, im_offset=0xFFFF, pc_h4=2 -> after next edge _branch=1, _offset=0xFFFFFFFC, _jump=0, _target=0.
- BEQ not taken: same as above but inum1=1 -> _branch=0, _offset=0.
- Jump: ctrl=2, pc_h4=3, instr_index=16 -> _jump=1, _target=0x30000040, _branch=0, _offset=0.
- BNE: ctrl=3, inum1=5, inum2=7, im_offset=0x0004 -> _branch=1, _offset=0x00000010. Then inum2=5 -> _branch=0.
- Idle and reset: ctrl=0 -> all outputs 0. With _jump=1 latched, assert reset between clock edges -> all outputs 0 at once, before any edge. Deassert reset with ctrl=2 -> _jump=1 after the next edge.
- Offset extremes: ctrl=1, equal operands, im_offset=0x8000 -> _offset=0xFFFE0000. im_offset=0x7FFF -> _offset=0x0001FFFC.
